rnn_sequencer: RTL

Avalon-MM initiator that drives the `rnn` accelerator's 8-word register window, so the HPS does not have to issue every parameter write itself. The HPS places a command list in SDRAM, programs base address and length through a small CSR slave, and writes GO. The block fetches each entry through a read master, replays it onto the RNN slave as a write, poll or read, and captures the final dense-layer result.

---
 rtl/rnn_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rnn_sequencer.sv
// Command-list sequencer: fetches 8-byte entries over an Avalon-MM read master and
// replays them onto the rnn register window. Optional POLL timeout via RNN_SEQ_TIMEOUT_EN.
module rnn_sequencer #(
  parameter int POLL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  csr_addr,
  input  logic        csr_write,
  input  logic        csr_read,
  input  logic [31:0] csr_writedata,
  output logic [31:0] csr_readdata,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest,
  input  logic        m_readdatavalid,
  output logic [2:0]  r_addr,
  output logic        r_write,
  output logic        r_read,
  output logic [31:0] r_writedata,
  input  logic [31:0] r_readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH0, S_WAIT0, S_FETCH1, S_WAIT1, S_EXEC, S_DONE, S_ERR
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_POLL  = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  state_t      state_reg, state_next;
  logic [31:0] list_base_reg;
  logic [15:0] list_len_reg;
  logic [31:0] result_reg;
  logic [15:0] entry_cnt_reg;
  logic [2:0]  op_addr_reg;
  logic [1:0]  op_code_reg;
  logic [31:0] data_reg;
  logic        bad_op_reg;
  logic        timeout_reg;

  logic        idle_like;
  logic        go;
  logic        last_entry;
  logic        poll_hit;
  logic        poll_expire;
  logic        exec_advance;
  logic        bad_op_set;
  logic        timeout_set;
  logic        fetching;
  logic [31:0] entry_addr;

`ifdef RNN_SEQ_TIMEOUT_EN
  localparam int PCW = $clog2(POLL_TIMEOUT + 1);
  logic [PCW-1:0] poll_cnt_reg;
  assign poll_expire = (poll_cnt_reg == PCW'(POLL_TIMEOUT - 1));
`else
  assign poll_expire = 1'b0;
`endif

  assign idle_like  = (state_reg == S_IDLE) || (state_reg == S_DONE) || (state_reg == S_ERR);
  assign go         = csr_write && (csr_addr == 2'd0) && csr_writedata[0] && idle_like;
  assign last_entry = (entry_cnt_reg == (list_len_reg - 16'd1));
  assign poll_hit   = |(r_readdata & data_reg);
  assign fetching   = (state_reg == S_FETCH0) || (state_reg == S_FETCH1);
  assign entry_addr = list_base_reg + {13'd0, entry_cnt_reg, 3'd0};

  always_comb begin
    state_next   = state_reg;
    exec_advance = 1'b0;
    bad_op_set   = 1'b0;
    timeout_set  = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) state_next = (list_len_reg == 16'd0) ? S_DONE : S_FETCH0;
      end
      S_FETCH0: if (!m_waitrequest)  state_next = S_WAIT0;
      S_WAIT0:  if (m_readdatavalid) state_next = S_FETCH1;
      S_FETCH1: if (!m_waitrequest)  state_next = S_WAIT1;
      S_WAIT1:  if (m_readdatavalid) state_next = S_EXEC;
      S_EXEC: begin
        case (op_code_reg)
          OP_WRITE, OP_READ: exec_advance = 1'b1;
          OP_POLL: begin
            if (poll_hit) begin
              exec_advance = 1'b1;
            end else if (poll_expire) begin
              timeout_set = 1'b1;
              state_next  = S_ERR;
            end
          end
          default: begin
            bad_op_set = 1'b1;
            state_next = S_ERR;
          end
        endcase
        if (exec_advance) state_next = last_entry ? S_DONE : S_FETCH0;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Strobes are gated by rst so they drop in the same cycle reset is raised.
  always_comb begin
    m_read      = fetching && !rst;
    m_address   = 32'd0;
    r_write     = 1'b0;
    r_read      = 1'b0;
    r_addr      = 3'd0;
    r_writedata = 32'd0;
    if (m_read) m_address = entry_addr + ((state_reg == S_FETCH1) ? 32'd4 : 32'd0);
    if ((state_reg == S_EXEC) && !rst) begin
      case (op_code_reg)
        OP_WRITE: begin
          r_write     = 1'b1;
          r_addr      = op_addr_reg;
          r_writedata = data_reg;
        end
        OP_POLL, OP_READ: begin
          r_read = 1'b1;
          r_addr = op_addr_reg;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    csr_readdata = 32'd0;
    if (csr_read) begin
      case (csr_addr)
        2'd0:    csr_readdata = {27'd0, bad_op_reg, timeout_reg, 1'b0,
                                 (state_reg == S_DONE), !idle_like};
        2'd1:    csr_readdata = list_base_reg;
        2'd2:    csr_readdata = {16'd0, list_len_reg};
        default: csr_readdata = result_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      list_base_reg <= 32'd0;
      list_len_reg  <= 16'd0;
      result_reg    <= 32'd0;
      entry_cnt_reg <= 16'd0;
      op_addr_reg   <= 3'd0;
      op_code_reg   <= 2'd0;
      data_reg      <= 32'd0;
      bad_op_reg    <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (csr_write && idle_like) begin
        if (csr_addr == 2'd1) list_base_reg <= {csr_writedata[31:3], 3'd0};
        if (csr_addr == 2'd2) list_len_reg  <= csr_writedata[15:0];
      end
      if (go) begin
        entry_cnt_reg <= 16'd0;
        bad_op_reg    <= 1'b0;
        timeout_reg   <= 1'b0;
      end
      if ((state_reg == S_WAIT0) && m_readdatavalid) begin
        op_addr_reg <= m_readdata[2:0];
        op_code_reg <= m_readdata[5:4];
      end
      if ((state_reg == S_WAIT1) && m_readdatavalid) data_reg <= m_readdata;
      if ((state_reg == S_EXEC) && (op_code_reg == OP_READ)) result_reg <= r_readdata;
      if (exec_advance && !last_entry) entry_cnt_reg <= entry_cnt_reg + 16'd1;
      if (bad_op_set)  bad_op_reg  <= 1'b1;
      if (timeout_set) timeout_reg <= 1'b1;
    end
  end

`ifdef RNN_SEQ_TIMEOUT_EN
  // Counts failed POLL reads of the current entry; cleared whenever not executing.
  always_ff @(posedge clk) begin
    if (rst || (state_reg != S_EXEC)) begin
      poll_cnt_reg <= '0;
    end else if ((op_code_reg == OP_POLL) && !poll_hit && !poll_expire) begin
      poll_cnt_reg <= poll_cnt_reg + 1'b1;
    end
  end
`endif

endmodule
